// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display controller: register map,
// segment pattern type and the hex-to-segment table (active-high, bit0=a .. bit6=g).
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam logic [3:0] REG_VALUE      = 4'd0;
  localparam logic [3:0] REG_RAW_EN     = 4'd1;
  localparam logic [3:0] REG_BLANK      = 4'd2;
  localparam logic [3:0] REG_BLINK_EN   = 4'd3;
  localparam logic [3:0] REG_BLINK_HALF = 4'd4;
  localparam logic [3:0] REG_BRIGHT     = 4'd5;
  localparam logic [3:0] REG_RAW_BASE   = 4'd8;

  localparam seg_t HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to seven-segment decoder (active-high pattern).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/seg7_display_ctrl.sv
// Avalon-MM seven-segment bank: per-digit hex/raw select, blanking, blink and
// global PWM brightness, with a registered segment bus.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter int          PWM_BITS    = 4,
  parameter int          ACTIVE_LOW  = 1,
  parameter int unsigned BLINK_RESET = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int unsigned        BRIGHT_MAX_INT = 2 ** PWM_BITS;
  localparam logic [PWM_BITS:0]  BRIGHT_MAX     = BRIGHT_MAX_INT[PWM_BITS:0];
  localparam logic [31:0]        BLINK_INIT     = BLINK_RESET;

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_rawEn;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic [NUM_DIGITS-1:0]   r_blinkEn;
  logic [31:0]             r_blinkHalf;
  logic [PWM_BITS:0]       r_bright;
  seg_t                    r_raw [NUM_DIGITS];

  logic [31:0]             r_blinkCnt;
  logic                    r_blinkPhase;
  logic [PWM_BITS-1:0]     r_pwmCnt;

  logic [31:0]             r_readData;
  logic [31:0]             w_readMux;
  logic [7*NUM_DIGITS-1:0] r_segOut;
  logic [7*NUM_DIGITS-1:0] w_lit;
  logic                    w_pwmOn;
  logic                    w_wrBlinkHalf;

  assign w_wrBlinkHalf = avs_write && (avs_address == REG_BLINK_HALF);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value     <= '0;
      r_rawEn     <= '0;
      r_blank     <= '0;
      r_blinkEn   <= '0;
      r_blinkHalf <= BLINK_INIT;
      r_bright    <= BRIGHT_MAX;
      for (int i = 0; i < NUM_DIGITS; i++) r_raw[i] <= '0;
    end else if (avs_write) begin
      case (avs_address)
        REG_VALUE:      r_value     <= avs_writedata[4*NUM_DIGITS-1:0];
        REG_RAW_EN:     r_rawEn     <= avs_writedata[NUM_DIGITS-1:0];
        REG_BLANK:      r_blank     <= avs_writedata[NUM_DIGITS-1:0];
        REG_BLINK_EN:   r_blinkEn   <= avs_writedata[NUM_DIGITS-1:0];
        REG_BLINK_HALF: r_blinkHalf <= avs_writedata;
        REG_BRIGHT: begin
          // Anything above full scale saturates to "always on".
          if (avs_writedata > BRIGHT_MAX_INT) r_bright <= BRIGHT_MAX;
          else                                r_bright <= avs_writedata[PWM_BITS:0];
        end
        default: ;
      endcase
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (avs_address == 4'(REG_RAW_BASE + i)) r_raw[i] <= avs_writedata[6:0];
      end
    end
  end

  // A BLINK_HALF write restarts the blink period with the digits visible.
  always_ff @(posedge clk) begin
    if (reset || w_wrBlinkHalf || (r_blinkHalf == 32'd0)) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b1;
    end else if (r_blinkCnt == r_blinkHalf - 32'd1) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt   <= r_blinkCnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_pwmCnt <= '0;
    else       r_pwmCnt <= r_pwmCnt + 1'b1;
  end

  assign w_pwmOn = {1'b0, r_pwmCnt} < r_bright;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg_t w_hex;
    seg_t w_pat;
    logic w_show;

    seg7_hex_decoder u_dec (
      .i_nibble (r_value[4*g +: 4]),
      .o_seg    (w_hex)
    );

    assign w_pat  = r_rawEn[g] ? r_raw[g] : w_hex;
    assign w_show = ~r_blank[g] & (~r_blinkEn[g] | r_blinkPhase) & w_pwmOn;
    assign w_lit[7*g +: 7] = w_pat & {7{w_show}};
  end

  always_ff @(posedge clk) begin
    if (reset) r_segOut <= (ACTIVE_LOW != 0) ? {7*NUM_DIGITS{1'b1}} : '0;
    else       r_segOut <= (ACTIVE_LOW != 0) ? ~w_lit : w_lit;
  end

  always_comb begin
    w_readMux = '0;
    case (avs_address)
      REG_VALUE:      w_readMux = 32'(r_value);
      REG_RAW_EN:     w_readMux = 32'(r_rawEn);
      REG_BLANK:      w_readMux = 32'(r_blank);
      REG_BLINK_EN:   w_readMux = 32'(r_blinkEn);
      REG_BLINK_HALF: w_readMux = r_blinkHalf;
      REG_BRIGHT:     w_readMux = 32'(r_bright);
      default: ;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (avs_address == 4'(REG_RAW_BASE + i)) w_readMux = 32'(r_raw[i]);
    end
  end

  // Sampling pre-edge state makes a same-cycle write return the old value.
  always_ff @(posedge clk) begin
    if (reset)         r_readData <= '0;
    else if (avs_read) r_readData <= w_readMux;
  end

  assign avs_readdata = r_readData;
  assign seg_out      = r_segOut;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: register vector table, directed
// blink/PWM/reset sequences and randomized traffic against a behavioural model.
module tb_seg7_display_ctrl;

  localparam int N     = 4;
  localparam int BHALF = 25000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [27:0] seg_out;

  always #5 clk = ~clk;

  seg7_display_ctrl #(
    .NUM_DIGITS  (N),
    .PWM_BITS    (4),
    .ACTIVE_LOW  (1),
    .BLINK_RESET (BHALF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .seg_out       (seg_out)
  );

  int testsRun = 0;
  int testsFailed = 0;

  logic [6:0]  hexTab [16];
  logic [15:0] mValue;
  logic [3:0]  mRawEn, mBlank, mBlinkEn;
  logic [31:0] mHalf;
  int          mBright;
  logic [6:0]  mRaw [N];
  longint      kBlink, pwmCycles;
  logic [27:0] expSeg;
  logic [31:0] expRead;
  bit          modelValid = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
  } regVec_t;
  regVec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Segment state is derived from elapsed cycles: blink phase flips every
  // mHalf cycles since the last restart, PWM position is cycles mod 16.
  function automatic logic [27:0] modelSeg();
    logic [27:0] s;
    logic [6:0]  pat;
    bit          phase, pwmOn, show;
    phase = (mHalf == 0) ? 1'b1 : (((kBlink / longint'(mHalf)) % 2) == 0);
    pwmOn = (pwmCycles % 16) < mBright;
    for (int d = 0; d < N; d++) begin
      pat  = mRawEn[d] ? mRaw[d] : hexTab[mValue[4*d +: 4]];
      show = !mBlank[d] && (!mBlinkEn[d] || phase) && pwmOn;
      s[7*d +: 7] = show ? ~pat : 7'h7F;
    end
    return s;
  endfunction

  function automatic logic [31:0] modelRead(input logic [3:0] a);
    case (a)
      4'd0: return {16'h0, mValue};
      4'd1: return {28'h0, mRawEn};
      4'd2: return {28'h0, mBlank};
      4'd3: return {28'h0, mBlinkEn};
      4'd4: return mHalf;
      4'd5: return 32'(mBright);
      4'd8, 4'd9, 4'd10, 4'd11: return {25'h0, mRaw[a - 4'd8]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mValue = '0; mRawEn = '0; mBlank = '0; mBlinkEn = '0;
    mHalf = BHALF; mBright = 16;
    for (int i = 0; i < N; i++) mRaw[i] = '0;
    kBlink = 0; pwmCycles = 0;
  endtask

  task automatic modelWrite(input logic [3:0] a, input logic [31:0] d);
    case (a)
      4'd0: mValue = d[15:0];
      4'd1: mRawEn = d[3:0];
      4'd2: mBlank = d[3:0];
      4'd3: mBlinkEn = d[3:0];
      4'd4: mHalf = d;
      4'd5: mBright = (d > 32'd16) ? 16 : int'(d);
      4'd8, 4'd9, 4'd10, 4'd11: mRaw[a - 4'd8] = d[6:0];
      default: ;
    endcase
  endtask

  task automatic tick();
    logic [27:0] preSeg;
    logic [31:0] preRd;
    bit wasRead;
    preSeg  = modelSeg();
    preRd   = modelRead(avs_address);
    wasRead = avs_read;
    @(posedge clk);
    if (reset) begin
      modelReset();
      expSeg = 28'hFFFFFFF;
      expRead = 32'h0;
      modelValid = 1;
    end else begin
      if (avs_write) modelWrite(avs_address, avs_writedata);
      if (avs_write && avs_address == 4'd4) kBlink = 0;
      else kBlink++;
      pwmCycles++;
      expSeg = preSeg;
      if (wasRead) expRead = preRd;
    end
    #1;
    if (modelValid) begin
      checkOutput("seg_out", 32'(seg_out), 32'(expSeg));
      if (wasRead) checkOutput("readdata", avs_readdata, expRead);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit wr, input bit rd,
                               input logic [3:0] addr, input logic [31:0] data);
    reset = rst; avs_write = wr; avs_read = rd;
    avs_address = addr; avs_writedata = data;
    tick();
    reset = 1'b0; avs_write = 1'b0; avs_read = 1'b0;
  endtask

  task automatic doWrite(input logic [3:0] a, input logic [31:0] d);
    applyStimulus(0, 1, 0, a, d);
  endtask

  task automatic doRead(input logic [3:0] a);
    applyStimulus(0, 0, 1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 4'd0, 32'h0);
  endtask

  task automatic countLit(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (seg_out[6:0] != 7'h7F) cnt++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    logic [27:0] want;
    hexTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs = '{
      '{4'd0,  32'hFFFF1234, 32'h00001234},
      '{4'd1,  32'h000000FF, 32'h0000000F},
      '{4'd2,  32'h00000005, 32'h00000005},
      '{4'd3,  32'h0000000A, 32'h0000000A},
      '{4'd4,  32'h00000007, 32'h00000007},
      '{4'd5,  32'h00000020, 32'h00000010},
      '{4'd5,  32'h00000011, 32'h00000010},
      '{4'd5,  32'h00000009, 32'h00000009},
      '{4'd8,  32'h000000FF, 32'h0000007F},
      '{4'd11, 32'h00000012, 32'h00000012},
      '{4'd6,  32'h00000055, 32'h00000000},
      '{4'd7,  32'hFFFFFFFF, 32'h00000000},
      '{4'd12, 32'h0000007F, 32'h00000000},
      '{4'd15, 32'h0000003C, 32'h00000000}
    };

    applyStimulus(1, 0, 0, 4'd0, 32'h0);
    applyStimulus(1, 0, 0, 4'd0, 32'h0);
    checkOutput("resetSeg", 32'(seg_out), 32'h0FFFFFFF);
    doRead(4'd5);
    checkOutput("resetBright", avs_readdata, 32'h10);
    doRead(4'd4);
    checkOutput("resetBlinkHalf", avs_readdata, 32'd25000000);

    doWrite(4'd0, 32'h0123);
    idle(1);
    want = {7'h40, 7'h79, 7'h24, 7'h30};
    checkOutput("value0123", 32'(seg_out), 32'(want));

    doWrite(4'd10, 32'h49);
    doWrite(4'd1, 32'h4);
    doWrite(4'd0, 32'h0123);
    idle(1);
    want = {7'h40, 7'h36, 7'h24, 7'h30};
    checkOutput("rawDigit2", 32'(seg_out), 32'(want));

    doWrite(4'd5, 32'd16);
    doWrite(4'd3, 32'h1);
    doWrite(4'd4, 32'd3);
    for (int j = 0; j < 12; j++) begin
      idle(1);
      checkOutput("blinkDigit0", 32'(seg_out[6:0]), ((j / 3) % 2 == 0) ? 32'h30 : 32'h7F);
    end
    doWrite(4'd4, 32'd0);
    countLit(10, cnt);
    checkOutput("blinkDisabledLit", 32'(cnt), 32'd10);
    doWrite(4'd2, 32'h8);
    idle(1);
    checkOutput("blankDigit3", 32'(seg_out[27:21]), 32'h7F);

    doWrite(4'd2, 32'h0);
    doWrite(4'd3, 32'h0);
    doWrite(4'd5, 32'd4);
    countLit(16, cnt);
    checkOutput("pwmBright4", 32'(cnt), 32'd4);
    doWrite(4'd5, 32'h20);
    doRead(4'd5);
    checkOutput("brightClamp", avs_readdata, 32'h10);
    countLit(16, cnt);
    checkOutput("pwmBrightFull", 32'(cnt), 32'd16);
    doWrite(4'd5, 32'd0);
    countLit(16, cnt);
    checkOutput("pwmBright0", 32'(cnt), 32'd0);

    for (int i = 0; i < 14; i++) begin
      doWrite(vecs[i].addr, vecs[i].wdata);
      doRead(vecs[i].addr);
      checkOutput("regVec", avs_readdata, vecs[i].expRead);
    end

    applyStimulus(0, 1, 1, 4'd0, 32'hABCD);
    checkOutput("readDuringWriteOld", avs_readdata, 32'h1234);

    doWrite(4'd5, 32'd16);
    doWrite(4'd4, 32'd2);
    doWrite(4'd3, 32'hF);
    idle(3);
    applyStimulus(1, 0, 0, 4'd0, 32'h0);
    checkOutput("midResetSeg", 32'(seg_out), 32'h0FFFFFFF);
    doRead(4'd3);
    checkOutput("midResetBlinkEn", avs_readdata, 32'h0);
    doRead(4'd4);
    checkOutput("midResetBlinkHalf", avs_readdata, 32'd25000000);

    for (int c = 0; c < 800; c++) begin
      int r;
      logic [3:0]  a;
      logic [31:0] d;
      r = int'($urandom_range(0, 99));
      a = 4'($urandom_range(0, 15));
      d = $urandom;
      if (a == 4'd4) d = $urandom_range(0, 6);
      if (a == 4'd5) d = $urandom_range(0, 40);
      if (r < 2)       applyStimulus(1, 0, 0, a, d);
      else if (r < 35) applyStimulus(0, 1, 0, a, d);
      else if (r < 45) applyStimulus(0, 1, 1, a, d);
      else if (r < 65) applyStimulus(0, 0, 1, a, d);
      else             idle(1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
